// File: rtl/register_bank_param.sv
// Parametrised register bank for the single-cycle MIPS datapath: two
// combinational read ports, a general write port, an independent link (JAL)
// write port, optional zero register, optional same-cycle bypass, a debug
// read port and a committed-write counter.
module register_bank_param #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int LINK_REG    = 31,
  parameter int PC_INC      = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS      = 1,
  parameter int CNT_W       = 16,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        Reg1,
  input  logic [ADDR_W-1:0]        Reg2,
  output logic signed [DATA_W-1:0] ReadData1,
  output logic signed [DATA_W-1:0] ReadData2,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegister,
  input  logic signed [DATA_W-1:0] WriteData,
  input  logic                     link_write,
  input  logic [DATA_W-1:0]        link_pc,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [CNT_W-1:0]         write_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] link_val;
  logic              gen_ok;
  logic [ADDR_W-1:0] raddr [3];
  logic [DATA_W-1:0] rdata [3];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign link_val = link_pc + DATA_W'(PC_INC);

  // General write lands only when in range, not to a hard-wired zero register,
  // and not colliding with a link write to the same register.
  always_comb begin
    gen_ok = RegWrite && in_range(WriteRegister)
             && !((ZERO_REG_EN != 0) && (WriteRegister == '0))
             && !(link_write && (WriteRegister == ADDR_W'(LINK_REG)));
  end

  // Register storage: asynchronous clear, writes commit on the rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (gen_ok)     regs[WriteRegister] <= WriteData;
      if (link_write) regs[LINK_REG]      <= link_val;
    end
  end

  // Committed-update counter: adds the number of registers actually written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) write_count <= '0;
    else          write_count <= write_count + CNT_W'(gen_ok) + CNT_W'(link_write);
  end

  // Read ports 0/1 are the datapath ports (bypassable); port 2 is debug (never bypassed).
  always_comb begin
    raddr[0] = Reg1;
    raddr[1] = Reg2;
    raddr[2] = dbg_addr;
    for (int unsigned p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (in_range(raddr[p]) && !((ZERO_REG_EN != 0) && (raddr[p] == '0))) begin
        rdata[p] = regs[raddr[p]];
        if ((BYPASS != 0) && reset_n && (p != 2)) begin
          if (link_write && (raddr[p] == ADDR_W'(LINK_REG)))
            rdata[p] = link_val;
          else if (gen_ok && (raddr[p] == WriteRegister))
            rdata[p] = WriteData;
        end
      end
    end
  end

  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];
  assign dbg_data  = rdata[2];

endmodule

// File: tb/tb_register_bank_param.sv
// Bench for register_bank_param: three configurations share one stimulus
// stream (default, no bypass, 24-entry bank with different link settings).
module tb_register_bank_param;

  logic               clock;
  logic               reset_n;
  logic [4:0]         Reg1, Reg2, WriteRegister, dbg_addr;
  logic               RegWrite, link_write;
  logic signed [31:0] WriteData;
  logic [31:0]        link_pc;

  logic signed [31:0] rd1 [3];
  logic signed [31:0] rd2 [3];
  logic [31:0]        dbg [3];
  logic [15:0]        wc0, wc1;
  logic [3:0]         wc2;

  int checks = 0;
  int errors = 0;

  // Per-configuration parameters as seen by the reference model.
  int nregs [3] = '{32, 32, 24};
  int link  [3] = '{31, 31, 20};
  int inc   [3] = '{1, 1, 4};
  int zen   [3] = '{1, 1, 0};
  int byp   [3] = '{1, 0, 1};
  int cntw  [3] = '{16, 16, 4};

  logic [31:0] mreg [3][32];
  int          mcnt [3];

  register_bank_param u_def (
    .clock(clock), .reset_n(reset_n), .Reg1(Reg1), .Reg2(Reg2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .link_write(link_write),
    .link_pc(link_pc), .dbg_addr(dbg_addr), .dbg_data(dbg[0]), .write_count(wc0));

  register_bank_param #(.BYPASS(0)) u_nob (
    .clock(clock), .reset_n(reset_n), .Reg1(Reg1), .Reg2(Reg2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .link_write(link_write),
    .link_pc(link_pc), .dbg_addr(dbg_addr), .dbg_data(dbg[1]), .write_count(wc1));

  register_bank_param #(.NUM_REGS(24), .LINK_REG(20), .PC_INC(4), .ZERO_REG_EN(0), .CNT_W(4)) u_n24 (
    .clock(clock), .reset_n(reset_n), .Reg1(Reg1), .Reg2(Reg2),
    .ReadData1(rd1[2]), .ReadData2(rd2[2]), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .link_write(link_write),
    .link_pc(link_pc), .dbg_addr(dbg_addr), .dbg_data(dbg[2]), .write_count(wc2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit gen_lands(input int c);
    int a = int'(WriteRegister);
    return RegWrite && (a < nregs[c]) && !(a == 0 && zen[c] != 0)
           && !(link_write && a == link[c]);
  endfunction

  function automatic logic [31:0] mread(input int c, input int a, input bit bypass_ok);
    if (a >= nregs[c]) return 32'h0;
    if (a == 0 && zen[c] != 0) return 32'h0;
    if (bypass_ok && byp[c] != 0 && reset_n) begin
      if (link_write && a == link[c]) return link_pc + 32'(inc[c]);
      if (gen_lands(c) && a == int'(WriteRegister)) return WriteData;
    end
    return mreg[c][a];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0;
      for (int r = 0; r < 32; r++) mreg[c][r] = '0;
    end
  endtask

  task automatic model_commit();
    if (!reset_n) return;
    for (int c = 0; c < 3; c++) begin
      int n = 0;
      if (gen_lands(c)) begin mreg[c][WriteRegister] = WriteData; n++; end
      if (link_write)   begin mreg[c][link[c]] = link_pc + 32'(inc[c]); n++; end
      mcnt[c] = (mcnt[c] + n) % (1 << cntw[c]);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] wcv [3];
    wcv[0] = 32'(wc0); wcv[1] = 32'(wc1); wcv[2] = 32'(wc2);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s cfg%0d rd1", tag, c), rd1[c], mread(c, int'(Reg1), 1'b1));
      chk($sformatf("%s cfg%0d rd2", tag, c), rd2[c], mread(c, int'(Reg2), 1'b1));
      chk($sformatf("%s cfg%0d dbg", tag, c), dbg[c], mread(c, int'(dbg_addr), 1'b0));
      chk($sformatf("%s cfg%0d cnt", tag, c), wcv[c], 32'(mcnt[c]));
    end
  endtask

  // Inputs are set at posedge+1; check before the edge, then commit the model.
  task automatic step(input string tag);
    @(negedge clock);
    check_all(tag);
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lw, input logic [31:0] lpc,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
    RegWrite = rw; WriteRegister = wa; WriteData = wd;
    link_write = lw; link_pc = lpc; Reg1 = r1; Reg2 = r2; dbg_addr = da;
  endtask

  // ---------------- directed table (default configuration) ----------------
  typedef struct {
    logic rw; logic [4:0] wa; logic [31:0] wd; logic lw; logic [31:0] lpc;
    logic [4:0] r1; logic [4:0] r2; logic [4:0] da;
    logic [31:0] e1; logic [31:0] e2; logic [31:0] ed; logic [31:0] ecnt;
  } vec_t;
  vec_t tbl [12];

  logic [3:0] saved_wc2;

  initial begin
    // expected values: pre-edge reads of u_def and write_count before the edge
    tbl[0]  = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  32'h0,  32'h0,  32'h0,  32'd0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  32'h0,  32'h0,  32'h0,  32'd0};
    tbl[2]  = '{1'b1, 5'd7,  32'hA5,       1'b1, 32'h40,       5'd7,  5'd31, 5'd7,  32'hA5, 32'h41, 32'h0,  32'd0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd7,  5'd31, 5'd31, 32'hA5, 32'h41, 32'h41, 32'd2};
    tbl[4]  = '{1'b1, 5'd31, 32'h99,       1'b1, 32'h10,       5'd31, 5'd31, 5'd31, 32'h11, 32'h11, 32'h41, 32'd2};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd31, 5'd7,  5'd31, 32'h11, 32'hA5, 32'h11, 32'd3};
    tbl[6]  = '{1'b1, 5'd3,  32'h77,       1'b0, 32'h0,        5'd3,  5'd3,  5'd3,  32'h77, 32'h77, 32'h0,  32'd3};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd3,  5'd3,  5'd3,  32'h77, 32'h77, 32'h77, 32'd4};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hFFFFFFFF, 5'd31, 5'd3,  5'd31, 32'h0,  32'h77, 32'h11, 32'd4};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd31, 5'd7,  5'd31, 32'h0,  32'hA5, 32'h0,  32'd5};
    tbl[10] = '{1'b1, 5'd5,  32'hFFFFFFFB, 1'b0, 32'h0,        5'd5,  5'd5,  5'd5,  32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0, 32'd5};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd5,  5'd0,  5'd5,  32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'd6};

    // reset state
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
    model_clear();
    step("reset");
    step("reset");
    reset_n = 1'b1;

    // load reg5, then assert reset mid-cycle while another write is pending
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 5'd5, 5'd5, 5'd5);
    step("load5");
    drive(1'b1, 5'd9, 32'hBEEF, 1'b0, 32'h0, 5'd5, 5'd9, 5'd5);
    #1 chk("pre_reset reg5", rd1[0], 32'h1234);
    #1 reset_n = 1'b0;
    model_clear();
    #1 chk("async_reset reg5", rd1[0], 32'h0);
    chk("async_reset cnt", 32'(wc0), 32'h0);
    chk("async_reset dbg", dbg[0], 32'h0);
    step("in_reset");
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd9, 5'd5, 5'd9);
    #1 chk("reset_dropped reg9", rd1[0], 32'h0);
    chk("reset_dropped cnt", 32'(wc0), 32'h0);
    step("post_reset");

    // directed table against hand-derived values and the model
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rw, tbl[i].wa, tbl[i].wd, tbl[i].lw, tbl[i].lpc, tbl[i].r1, tbl[i].r2, tbl[i].da);
      #1;
      chk($sformatf("tbl%0d rd1", i), rd1[0], tbl[i].e1);
      chk($sformatf("tbl%0d rd2", i), rd2[0], tbl[i].e2);
      chk($sformatf("tbl%0d dbg", i), dbg[0], tbl[i].ed);
      chk($sformatf("tbl%0d cnt", i), 32'(wc0), tbl[i].ecnt);
      step($sformatf("tbl%0d", i));
    end

    // bypass versus no bypass on a rewrite of reg3
    drive(1'b1, 5'd3, 32'h55, 1'b0, 32'h0, 5'd0, 5'd3, 5'd3);
    #1 chk("nob old value", rd2[1], 32'h77);
    chk("byp new value", rd2[0], 32'h55);
    chk("byp dbg old", dbg[0], 32'h77);
    step("bypass_cmp");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd3, 5'd3);
    #1 chk("nob after edge", rd2[1], 32'h55);
    step("bypass_after");

    // out-of-range address on the 24-entry bank
    drive(1'b1, 5'd30, 32'hDEAD, 1'b0, 32'h0, 5'd30, 5'd30, 5'd30);
    saved_wc2 = wc2;
    #1 chk("n24 oor rd1", rd1[2], 32'h0);
    chk("n24 oor dbg", dbg[2], 32'h0);
    step("n24_oor");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd30, 5'd30, 5'd30);
    #1 chk("n24 oor cnt", 32'(wc2), 32'(saved_wc2));
    chk("n24 oor after", rd1[2], 32'h0);
    step("n24_after");

    // randomized traffic with occasional resets, checked against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wa = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd20;
      if ($urandom_range(0, 7) == 0) wa = 5'd0;
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 59) == 0) begin
        reset_n = 1'b0;
        model_clear();
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
